// File: rtl/periferico_uart_tx.sv
`timescale 1ns/1ps
// Memory-mapped 8N1 UART transmitter: byte FIFO written over the CPU bus, serialised on tx.
// Latency: DATO write at edge N, start bit driven after N+1 when idle; bus reads registered (1 cycle).
// Backpressure: none on the bus; a DATO write to a full FIFO (with no pop that cycle) is dropped and sets desborde.
//
// Ports: clk, reset (async active-low), hab_escritura/dir/dat_escritura (bus write),
//        dat_lectura/sel (registered read data and address-hit flag), tx (serial out, idles high).
// Option: define UART_TX_PARIDAD_EN to add an even-parity bit (frame 11*D, ESTADO bit4 = 1).
module periferico_uart_tx #(
  parameter logic [31:0] BASE            = 32'h0000_1000,
  parameter int          PROFUNDIDAD     = 8,
  parameter logic [15:0] DIVISOR_INICIAL = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hab_escritura,
  input  logic [31:0] dir,
  input  logic [31:0] dat_escritura,
  output logic [31:0] dat_lectura,
  output logic        sel,
  output logic        tx
);

  localparam int AW = $clog2(PROFUNDIDAD);
  localparam int CW = AW + 1;

`ifdef UART_TX_PARIDAD_EN
  typedef enum logic [2:0] {REPOSO, INICIO, DATOS, PARIDAD, PARADA} estado_t;
  localparam logic PARIDAD_HAB = 1'b1;
`else
  typedef enum logic [1:0] {REPOSO, INICIO, DATOS, PARADA} estado_t;
  localparam logic PARIDAD_HAB = 1'b0;
`endif

  estado_t estado_q, estado_d;

  logic [7:0]    mem_q [PROFUNDIDAD];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          desborde_q;
  logic [15:0]   divisor_q;
  logic [15:0]   periodo_q;
  logic [15:0]   timer_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          paridad_q;
  logic [31:0]   dat_lectura_q, dat_lectura_d;
  logic          sel_q;

  logic acierto, esc, llena, vacia, fin_bit, pop, push, desborde_evt;
  logic [1:0] off;
  logic [31:0] rd_estado;
  logic unused_bits;

  assign unused_bits = ^{dir[1:0], dat_escritura[31:16]};

  assign acierto = (dir[31:4] == BASE[31:4]);
  assign off     = dir[3:2];
  assign esc     = hab_escritura & acierto;
  assign llena   = (count_q == CW'(PROFUNDIDAD));
  assign vacia   = (count_q == '0);
  assign fin_bit = (timer_q == periodo_q - 16'd1);

  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push         = esc && (off == 2'd0) && (!llena || pop);
  assign desborde_evt = esc && (off == 2'd0) && llena && !pop;

  // Next state and pop request
  always_comb begin
    estado_d = estado_q;
    pop      = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (!vacia) begin
          pop      = 1'b1;
          estado_d = INICIO;
        end
      end
      INICIO: if (fin_bit) estado_d = DATOS;
      DATOS: begin
        if (fin_bit && bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARIDAD_EN
          estado_d = PARIDAD;
`else
          estado_d = PARADA;
`endif
        end
      end
`ifdef UART_TX_PARIDAD_EN
      PARIDAD: if (fin_bit) estado_d = PARADA;
`endif
      PARADA: begin
        if (fin_bit) begin
          if (!vacia) begin
            pop      = 1'b1;
            estado_d = INICIO;
          end else begin
            estado_d = REPOSO;
          end
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  // Serial output decoded from state; REPOSO during reset keeps tx high asynchronously.
  always_comb begin
    tx = 1'b1;
    case (estado_q)
      INICIO:  tx = 1'b0;
      DATOS:   tx = shift_q[0];
`ifdef UART_TX_PARIDAD_EN
      PARIDAD: tx = paridad_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado_q <= REPOSO;
    else        estado_q <= estado_d;
  end

  // Bit timer, shifter and per-frame latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      periodo_q <= 16'd1;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      paridad_q <= 1'b0;
    end else if (pop) begin
      shift_q   <= mem_q[rd_ptr_q];
      paridad_q <= ^mem_q[rd_ptr_q];
      // Period frozen per frame so mid-frame DIVISOR writes only affect the next one.
      periodo_q <= (divisor_q == 16'd0) ? 16'd1 : divisor_q;
      timer_q   <= '0;
      bit_cnt_q <= '0;
    end else if (estado_q != REPOSO) begin
      if (fin_bit) begin
        timer_q <= '0;
        if (estado_q == DATOS) begin
          shift_q   <= {1'b0, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end else begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end

  // FIFO storage has no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dat_escritura[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      desborde_q <= 1'b0;
      divisor_q  <= DIVISOR_INICIAL;
    end else begin
      if (desborde_evt)
        desborde_q <= 1'b1;
      else if (esc && off == 2'd1 && dat_escritura[3])
        desborde_q <= 1'b0;
      if (esc && off == 2'd2)
        divisor_q <= dat_escritura[15:0];
    end
  end

  // Read path
  always_comb begin
    rd_estado            = '0;
    rd_estado[0]         = llena;
    rd_estado[1]         = vacia;
    rd_estado[2]         = (estado_q != REPOSO);
    rd_estado[3]         = desborde_q;
    rd_estado[4]         = PARIDAD_HAB;
    rd_estado[8 +: CW]   = count_q;
  end

  always_comb begin
    dat_lectura_d = '0;
    if (acierto) begin
      case (off)
        2'd1:    dat_lectura_d = rd_estado;
        2'd2:    dat_lectura_d = {16'd0, divisor_q};
        default: dat_lectura_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dat_lectura_q <= '0;
      sel_q         <= 1'b0;
    end else begin
      dat_lectura_q <= dat_lectura_d;
      sel_q         <= acierto;
    end
  end

  assign dat_lectura = dat_lectura_q;
  assign sel         = sel_q;

endmodule

// File: tb/tb_periferico_uart_tx.sv
`timescale 1ns/1ps
// Bench for periferico_uart_tx: bus-driven stimulus, an independent serial receiver
// that decodes tx by mid-bit sampling, and a queue of expected bytes.
module tb_periferico_uart_tx;

`ifdef UART_TX_PARIDAD_EN
  localparam int          NBITS_TRAMA = 11;
  localparam logic [31:0] BIT_PAR     = 32'h10;
`else
  localparam int          NBITS_TRAMA = 10;
  localparam logic [31:0] BIT_PAR     = 32'h0;
`endif
  localparam logic [31:0] A_DATO = 32'h0000_1000;
  localparam logic [31:0] A_EST  = 32'h0000_1004;
  localparam logic [31:0] A_DIV  = 32'h0000_1008;
  localparam logic [31:0] A_RES  = 32'h0000_100C;
  localparam logic [31:0] EST_REPOSO = 32'h2 | BIT_PAR;

  logic        clk = 1'b0;
  logic        reset;
  logic        hab_escritura;
  logic [31:0] dir, dat_escritura, dat_lectura;
  logic        sel, tx;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  logic [7:0] exp_q [$];
  logic [7:0] rx_q  [$];
  int         fall_q[$];
  int         rx_d;
  bit         rx_abort;

  periferico_uart_tx #(
    .BASE(32'h0000_1000), .PROFUNDIDAD(8), .DIVISOR_INICIAL(16'd434)
  ) dut (
    .clk(clk), .reset(reset), .hab_escritura(hab_escritura), .dir(dir),
    .dat_escritura(dat_escritura), .dat_lectura(dat_lectura), .sel(sel), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    hab_escritura = 1'b1; dir = a; dat_escritura = d;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    hab_escritura = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    hab_escritura = 1'b0; dir = a;
    @(negedge clk);
    d = dat_lectura;
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] r;
    int n;
    r = '0; n = 0;
    do begin
      bus_read(A_EST, r);
      n++;
    end while (r !== EST_REPOSO && n < budget);
    chk("reposo", r, EST_REPOSO);
  endtask

  // Receiver: finds the start bit, samples each bit in its middle using the programmed period.
  initial begin
    int d, t0;
    logic [7:0] b;
    logic p, stop;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        d = (rx_d == 0) ? 1 : rx_d;
        t0 = cyc;
        rx_abort = 1'b0;
        b = '0;
        p = 1'b0;
        for (int k = 0; k < d + d / 2; k++) begin
          @(negedge clk); if (reset !== 1'b1) rx_abort = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          b[i] = tx;
          for (int k = 0; k < d; k++) begin
            @(negedge clk); if (reset !== 1'b1) rx_abort = 1'b1;
          end
        end
`ifdef UART_TX_PARIDAD_EN
        p = tx;
        for (int k = 0; k < d; k++) begin
          @(negedge clk); if (reset !== 1'b1) rx_abort = 1'b1;
        end
`endif
        stop = tx;
        if (!rx_abort) begin
          chk("bit_parada", stop, 1);
`ifdef UART_TX_PARIDAD_EN
          chk("paridad", p, ^b);
`endif
          rx_q.push_back(b);
          fall_q.push_back(t0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  a5;
    logic [7:0]  v;
    logic        expbit;
    int          w0, target, fidx, d, lows, nchk;

    reset = 1'b0; hab_escritura = 1'b0; dir = '0; dat_escritura = '0;
    rx_d = 434; rx_abort = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_dat", dat_lectura, 0);
    chk("rst_sel", sel, 0);
    @(negedge clk) reset = 1'b1;
    bus_read(A_EST, r);  chk("rst_estado", r, EST_REPOSO);
    chk("sel_hit", sel, 1);
    bus_read(A_DIV, r);  chk("rst_divisor", r, 434);
    bus_read(32'h0000_2004, r); chk("fuera_dat", r, 0);
    chk("fuera_sel", sel, 0);
    bus_write(A_RES, 32'hFFFF_FFFF);
    bus_read(A_RES, r);  chk("reservado", r, 0);
    bus_read(A_DATO, r); chk("dato_lee0", r, 0);
    chk("tx_reposo", tx, 1);

    // DIVISOR upper bits are not stored
    bus_write(A_DIV, 32'hABCD_0004); rx_d = 4;
    bus_read(A_DIV, r); chk("divisor_rw", r, 4);

    // Single byte, cycle-exact waveform
    a5 = 8'hA5;
    exp_q.push_back(a5);
    bus_write(A_DATO, {24'd0, a5});
    @(negedge clk); hab_escritura = 1'b0; dir = A_EST;
    chk("tx_pre", tx, 1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c < 4)       expbit = 1'b0;
      else if (c < 36) expbit = a5[(c - 4) / 4];
      else             expbit = 1'b1;
      chk("trama_a5", tx, expbit);
    end
    @(negedge clk); chk("ocupado_fin", dat_lectura, 32'h6 | BIT_PAR);
    @(negedge clk); chk("reposo_40", dat_lectura, EST_REPOSO);

    // Full / overflow, then push+pop on the full FIFO
    bus_write(A_DIV, 100); rx_d = 100;
    bus_idle();
    fidx = fall_q.size();
    w0 = 0;
    for (int i = 0; i < 10; i++) begin
      bus_write(A_DATO, i);
      if (i == 0) w0 = cyc + 1;
      if (i <= 8) exp_q.push_back(8'(i));
    end
    bus_read(A_EST, r); chk("desborde", r, 32'h80D | BIT_PAR);
    bus_write(A_EST, 8);
    bus_read(A_EST, r); chk("desborde_clr", r, 32'h805 | BIT_PAR);
    target = w0 + 1 + NBITS_TRAMA * 100;
    while (cyc < target - 2) @(negedge clk);
    bus_write(A_DATO, 32'h55);
    exp_q.push_back(8'h55);
    bus_read(A_EST, r); chk("push_pop_lleno", r, 32'h805 | BIT_PAR);
    wait_idle(12000);
    chk("tramas_desborde", fall_q.size() - fidx, 10);
    for (int k = fidx + 1; k < fidx + 10 && k < fall_q.size(); k++)
      chk("sin_hueco", fall_q[k] - fall_q[k-1], NBITS_TRAMA * 100);

    // Randomized batches of 5 with random divisor (0 acts as 1): exercises wrap-around
    for (int bt = 0; bt < 6; bt++) begin
      d = $urandom_range(0, 6);
      bus_write(A_DIV, d); rx_d = d;
      bus_read(A_DIV, r); chk("divisor_rand", r, d);
      for (int i = 0; i < 5; i++) begin
        v = 8'($urandom);
        exp_q.push_back(v);
        bus_write(A_DATO, {24'd0, v});
      end
      bus_idle();
      wait_idle(2000);
    end

    // Reset during DATOS
    bus_write(A_DIV, 8); rx_d = 8;
    bus_write(A_DATO, 0);
    bus_write(A_DATO, 0);
    bus_idle();
    repeat (30) @(negedge clk);
    chk("tx_datos", tx, 0);
    #2 reset = 1'b0;
    #1 chk("tx_reset_async", tx, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    nchk = rx_q.size();
    bus_read(A_EST, r); chk("post_reset_estado", r, EST_REPOSO);
    lows = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("sin_trama", lows, 0);
    chk("rx_sin_cambio", rx_q.size(), nchk);

    // Received stream against expected
    chk("rx_total", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk("rx_byte", rx_q[i], exp_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
